// File: rtl/timer_irq_ctrl.sv
// Interrupt controller for the timer block: per-source rising-edge capture into sticky pending
// bits, overrun tracking, software enable mask, saturating event counter and a registered IRQ
// line with a re-assert holdoff window.
module timer_irq_ctrl #(
  parameter int unsigned NUM_SRC     = 3,
  parameter int unsigned HOLDOFF_CYC = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_SRC-1:0]   intr_src_i,
  input  logic                 mask_we_i,
  input  logic [NUM_SRC-1:0]   mask_d_i,
  input  logic                 clr_we_i,
  input  logic [2*NUM_SRC-1:0] clr_d_i,
  input  logic                 cnt_clr_i,
  output logic [NUM_SRC-1:0]   pending_o,
  output logic [NUM_SRC-1:0]   ovr_o,
  output logic [NUM_SRC-1:0]   mask_o,
  output logic [CNT_W-1:0]     evt_cnt_o,
  output logic                 irq_o
);

  localparam int unsigned PopW  = $clog2(NUM_SRC + 1);
  localparam int unsigned SumW  = CNT_W + 1;
  localparam int unsigned HcntW = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
  localparam logic [HcntW-1:0] HcntLoad = HcntW'((HOLDOFF_CYC > 0) ? HOLDOFF_CYC - 1 : 0);

  typedef enum logic [1:0] {StIdle, StAssert, StHold} state_e;

  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] src_rise;
  logic [NUM_SRC-1:0] pend_clr, ovr_clr;
  logic [NUM_SRC-1:0] pending_d, pending_q;
  logic [NUM_SRC-1:0] ovr_d, ovr_q;
  logic [NUM_SRC-1:0] mask_d, mask_q;
  logic [PopW-1:0]    popcnt;
  logic [CNT_W-1:0]   cnt_base;
  logic [SumW-1:0]    cnt_sum;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic               act;
  state_e             state_d, state_q;
  logic [HcntW-1:0]   hcnt_d, hcnt_q;
  logic               irq_q;

  assign src_rise = intr_src_i & ~src_q;
  assign pend_clr = clr_we_i ? clr_d_i[NUM_SRC-1:0] : '0;
  assign ovr_clr  = clr_we_i ? clr_d_i[2*NUM_SRC-1:NUM_SRC] : '0;
  // act uses registered pending/mask so mask writes and pending clears drop IRQ identically
  assign act      = |(pending_q & mask_q);

  // Sticky status: a same-cycle set always wins over a clear
  always_comb begin
    pending_d = src_rise | (pending_q & ~pend_clr);
    ovr_d     = (src_rise & pending_q & ~pend_clr) | (ovr_q & ~ovr_clr);
    mask_d    = mask_we_i ? mask_d_i : mask_q;
  end

  // Event counter: optional clear first, then add this cycle's edges with saturation
  always_comb begin
    popcnt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      popcnt = popcnt + PopW'(src_rise[i]);
    end
    cnt_base = cnt_clr_i ? '0 : cnt_q;
    cnt_sum  = {1'b0, cnt_base} + SumW'(popcnt);
    cnt_d    = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  // IRQ FSM next state; act is ignored while the holdoff window runs
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    unique case (state_q)
      StIdle: begin
        if (act) state_d = StAssert;
      end
      StAssert: begin
        if (!act) begin
          if (HOLDOFF_CYC == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StHold;
            hcnt_d  = HcntLoad;
          end
        end
      end
      StHold: begin
        if (hcnt_q == '0) state_d = StIdle;
        else              hcnt_d  = hcnt_q - HcntW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_q     <= '0;
      pending_q <= '0;
      ovr_q     <= '0;
      mask_q    <= '0;
      cnt_q     <= '0;
      state_q   <= StIdle;
      hcnt_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      src_q     <= intr_src_i;
      pending_q <= pending_d;
      ovr_q     <= ovr_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      irq_q     <= (state_d == StAssert);
    end
  end

  assign pending_o = pending_q;
  assign ovr_o     = ovr_q;
  assign mask_o    = mask_q;
  assign evt_cnt_o = cnt_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Bench for timer_irq_ctrl: two instances (8-bit and 2-bit counter) share the stimulus and are
// compared every cycle against a behavioural model, plus hand-computed literal expectations.
module tb_timer_irq_ctrl;

  localparam int unsigned N = 3;
  localparam int unsigned H = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   src;
  logic           mask_we;
  logic [N-1:0]   mask_d;
  logic           clr_we;
  logic [2*N-1:0] clr_d;
  logic           cnt_clr;

  logic [N-1:0] a_pend, a_ovr, a_mask, b_pend, b_ovr, b_mask;
  logic [7:0]   a_cnt;
  logic [1:0]   b_cnt;
  logic         a_irq, b_irq;

  always #5 clk = ~clk;

  timer_irq_ctrl #(.NUM_SRC(N), .HOLDOFF_CYC(H), .CNT_W(8)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .intr_src_i(src), .mask_we_i(mask_we), .mask_d_i(mask_d),
    .clr_we_i(clr_we), .clr_d_i(clr_d), .cnt_clr_i(cnt_clr), .pending_o(a_pend),
    .ovr_o(a_ovr), .mask_o(a_mask), .evt_cnt_o(a_cnt), .irq_o(a_irq)
  );

  timer_irq_ctrl #(.NUM_SRC(N), .HOLDOFF_CYC(H), .CNT_W(2)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .intr_src_i(src), .mask_we_i(mask_we), .mask_d_i(mask_d),
    .clr_we_i(clr_we), .clr_d_i(clr_d), .cnt_clr_i(cnt_clr), .pending_o(b_pend),
    .ovr_o(b_ovr), .mask_o(b_mask), .evt_cnt_o(b_cnt), .irq_o(b_irq)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, got, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [N-1:0] m_src, m_pend, m_ovr, m_mask, m_rise, m_clrp, m_clro;
  int unsigned  m_cnt_a, m_cnt_b, m_k;
  bit           m_irq, m_act;
  int           m_block;   // edges left during which IRQ is forced low

  always @(posedge clk) begin
    if (rst) begin
      m_src = '0; m_pend = '0; m_ovr = '0; m_mask = '0;
      m_cnt_a = 0; m_cnt_b = 0; m_irq = 1'b0; m_block = 0;
    end else begin
      m_rise = src & ~m_src;
      m_act  = |(m_pend & m_mask);
      if (m_block > 0) m_block--;
      else if (!m_irq && m_act) m_irq = 1'b1;
      else if (m_irq && !m_act) begin
        m_irq   = 1'b0;
        m_block = H;
      end
      m_clrp = clr_we ? clr_d[N-1:0] : '0;
      m_clro = clr_we ? clr_d[2*N-1:N] : '0;
      m_ovr  = (m_ovr & ~m_clro) | (m_rise & m_pend & ~m_clrp);
      m_pend = m_rise | (m_pend & ~m_clrp);
      if (mask_we) m_mask = mask_d;
      m_k = $countones(m_rise);
      m_cnt_a = (cnt_clr ? 0 : m_cnt_a) + m_k;
      if (m_cnt_a > 255) m_cnt_a = 255;
      m_cnt_b = (cnt_clr ? 0 : m_cnt_b) + m_k;
      if (m_cnt_b > 3) m_cnt_b = 3;
      m_src = src;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("a_pending", 32'(a_pend), 32'(m_pend));
      check("a_ovr",     32'(a_ovr),  32'(m_ovr));
      check("a_mask",    32'(a_mask), 32'(m_mask));
      check("a_cnt",     32'(a_cnt),  m_cnt_a);
      check("a_irq",     32'(a_irq),  32'(m_irq));
      check("b_pending", 32'(b_pend), 32'(m_pend));
      check("b_ovr",     32'(b_ovr),  32'(m_ovr));
      check("b_cnt",     32'(b_cnt),  m_cnt_b);
      check("b_irq",     32'(b_irq),  32'(m_irq));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  int  low;
  bit  rose;

  initial begin
    rst = 1'b1; src = '0; mask_we = 1'b0; mask_d = '0;
    clr_we = 1'b0; clr_d = '0; cnt_clr = 1'b0;
    cyc(); cyc();
    check("rst_pending", 32'(a_pend), 0);
    check("rst_irq",     32'(a_irq),  0);
    check("rst_cnt",     32'(a_cnt),  0);
    rst = 1'b0;
    chk_en = 1'b1;

    // 1: single pulse on src[0] with mask=001
    mask_we = 1'b1; mask_d = 3'b001; cyc();
    mask_we = 1'b0; src = 3'b001; cyc();
    check("t1_pending", 32'(a_pend), 1);
    check("t1_irq_early", 32'(a_irq), 0);
    check("t1_cnt", 32'(a_cnt), 1);
    src = '0; cyc();
    check("t1_irq", 32'(a_irq), 1);
    clr_we = 1'b1; clr_d = 6'b000001; cyc();
    clr_we = 1'b0;
    repeat (8) cyc();

    // 2: masked pending, then enable via mask write
    mask_we = 1'b1; mask_d = 3'b000; src = 3'b010; cyc();
    mask_we = 1'b0; src = '0;
    repeat (3) cyc();
    check("t2_irq_masked", 32'(a_irq), 0);
    mask_we = 1'b1; mask_d = 3'b010; cyc();
    mask_we = 1'b0;
    check("t2_irq_write_edge", 32'(a_irq), 0);
    cyc();
    check("t2_irq_on", 32'(a_irq), 1);
    clr_we = 1'b1; clr_d = 6'b000010; cyc();
    clr_we = 1'b0;
    repeat (8) cyc();

    // 3: overrun set, overrun clear, edge with same-cycle pending clear
    mask_we = 1'b1; mask_d = '0; clr_we = 1'b1; clr_d = 6'b111111; cyc();
    mask_we = 1'b0; clr_we = 1'b0;
    src = 3'b001; cyc();
    src = '0; cyc();
    src = 3'b001; cyc();
    check("t3_ovr_set", 32'(a_ovr), 1);
    check("t3_pending", 32'(a_pend), 1);
    src = '0; clr_we = 1'b1; clr_d = 6'b001000; cyc();
    check("t3_ovr_clr", 32'(a_ovr), 0);
    src = 3'b001; clr_d = 6'b000001; cyc();
    check("t3_ovr_noset", 32'(a_ovr), 0);
    check("t3_pending_set_wins", 32'(a_pend), 1);
    src = '0; clr_we = 1'b0; cyc();

    // 4: holdoff window with an edge arriving during HOLD
    mask_we = 1'b1; mask_d = 3'b111; clr_we = 1'b1; clr_d = 6'b111111; cyc();
    mask_we = 1'b0; clr_we = 1'b0;
    src = 3'b001; cyc();
    src = '0; cyc();
    check("t4_irq_on", 32'(a_irq), 1);
    clr_we = 1'b1; clr_d = 6'b000111; cyc();
    clr_we = 1'b0;
    check("t4_irq_still_on", 32'(a_irq), 1);
    low = 0; rose = 1'b0;
    for (int i = 0; i < 20 && !rose; i++) begin
      if (i == 1) src = 3'b100;
      if (i == 2) src = '0;
      cyc();
      if (a_irq) rose = 1'b1;
      else low++;
    end
    check("t4_low_cycles", 32'(low), H + 1);
    check("t4_rose", 32'(rose), 1);
    clr_we = 1'b1; clr_d = 6'b111111; cyc();
    clr_we = 1'b0;
    repeat (8) cyc();

    // 5: counter saturation (2-bit instance) and clear-then-add
    cnt_clr = 1'b1; cyc();
    cnt_clr = 1'b0;
    check("t5_cnt_clr", 32'(b_cnt), 0);
    repeat (5) begin
      src = 3'b001; cyc();
      src = '0; cyc();
    end
    check("t5_sat_b", 32'(b_cnt), 3);
    check("t5_cnt_a", 32'(a_cnt), 5);
    cnt_clr = 1'b1; src = 3'b011; cyc();
    check("t5_clr_add_b", 32'(b_cnt), 2);
    check("t5_clr_add_a", 32'(a_cnt), 2);
    cnt_clr = 1'b0; src = '0; cyc();

    // 6: reset during ASSERT with source held high
    clr_we = 1'b1; clr_d = 6'b111111; cyc();
    clr_we = 1'b0;
    repeat (8) cyc();
    src = 3'b100; cyc(); cyc();
    check("t6_irq_on", 32'(a_irq), 1);
    rst = 1'b1; cyc();
    check("t6_rst_pending", 32'(a_pend), 0);
    check("t6_rst_ovr",     32'(a_ovr),  0);
    check("t6_rst_mask",    32'(a_mask), 0);
    check("t6_rst_cnt",     32'(a_cnt),  0);
    check("t6_rst_irq",     32'(a_irq),  0);
    rst = 1'b0; mask_we = 1'b1; mask_d = 3'b100; cyc();
    mask_we = 1'b0;
    check("t6_pending_recount", 32'(a_pend), 4);
    check("t6_irq_early", 32'(a_irq), 0);
    cyc();
    check("t6_irq_on_again", 32'(a_irq), 1);
    src = '0;
    repeat (3) cyc();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
